// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking for the shared switch-configuration engine.
// Optional hold watchdog enabled by defining RR_ARB_WATCHDOG_EN.
module rr_lock_arbiter #(
   parameter int P_CHANNEL_NUM = 8,
   parameter int P_IDX_W       = $clog2(P_CHANNEL_NUM),
   parameter int P_MAX_HOLD    = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_arb_en,
   input  logic [P_CHANNEL_NUM-1:0] i_req,
   input  logic [P_CHANNEL_NUM-1:0] i_release,
   output logic [P_CHANNEL_NUM-1:0] o_grant,
   output logic                     o_grant_valid,
   output logic [P_IDX_W-1:0]       o_grant_idx,
   output logic                     o_timeout
);
   localparam int N = P_CHANNEL_NUM;
   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_LOCKED = 1'b1;

   if (P_CHANNEL_NUM < 2 || P_MAX_HOLD < 2) begin : g_bad_param
      $error("rr_lock_arbiter: P_CHANNEL_NUM and P_MAX_HOLD must be >= 2");
   end

   logic [0:0]         state_q;
   logic [N-1:0]       grant_q;
   logic [N-1:0]       ptr_q;
   logic [P_IDX_W-1:0] idx_q;
   logic               timeout_q;

   // First requester at or above the pointer, wrapping: borrow chain of the doubled vector.
   logic [2*N-1:0]     req_dbl, diff, gnt_dbl;
   logic [N-1:0]       sel;
   logic [P_IDX_W-1:0] sel_idx;

   assign req_dbl = {i_req, i_req};
   assign diff    = req_dbl - {{N{1'b0}}, ptr_q};
   assign gnt_dbl = req_dbl & ~diff;
   assign sel     = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < N; i++)
         if (sel[i]) sel_idx = sel_idx | P_IDX_W'(i);
   end

   logic locked, owner_release, owner_drop, expire, end_grant, take;

   assign locked        = (state_q == S_LOCKED);
   assign owner_release = |(i_release & grant_q);
   assign owner_drop    = ~|(i_req & grant_q);

`ifdef RR_ARB_WATCHDOG_EN
   localparam int HOLD_W = $clog2(P_MAX_HOLD + 1);
   logic [HOLD_W-1:0] hold_q;

   // A release or request drop on the expiry edge wins, so no timeout pulse.
   assign expire = locked && (hold_q == HOLD_W'(P_MAX_HOLD - 1))
                   && !owner_release && !owner_drop;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         hold_q <= '0;
      else if (take || end_grant)
         hold_q <= '0;
      else if (locked && hold_q < HOLD_W'(P_MAX_HOLD))
         hold_q <= hold_q + 1'b1;
   end
`else
   assign expire = 1'b0;
`endif

   assign end_grant = locked && (owner_release || owner_drop || expire);
   assign take      = (!locked || end_grant) && i_arb_en && (|i_req);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         idx_q     <= '0;
         ptr_q     <= N'(1);
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= expire;
         if (take) begin
            state_q <= S_LOCKED;
            grant_q <= sel;
            idx_q   <= sel_idx;
            ptr_q   <= {sel[N-2:0], sel[N-1]};
         end else if (end_grant) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
         end
      end
   end

   assign o_grant       = grant_q;
   assign o_grant_valid = |grant_q;
   assign o_grant_idx   = idx_q;
   assign o_timeout     = timeout_q;
endmodule
